irq_ctl: RTL and testbench
==========================

# irq_ctl

Interrupt controller between the peripheral timers/counters and the CPU core. It collects level-sensitive `interrupt_request` lines from up to `NSRC` peripherals and arbitrates them into one request plus vector number for the core. It runs the acknowledge/return handshake with the core and sends a one-cycle `interrupt_executed` pulse back to the selected peripheral, which then clears its flag.

## Interface
- `NSRC`, 8: number of request sources (2..16); source index i maps to vector `VEC_BASE + i`.
- `VEC_BASE`, 1: vector number of source 0.
- `VW`, 5: width of the vector output; `VEC_BASE + NSRC - 1` must fit in `VW` bits.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset; all state is cleared while low.
- `irq_req`  in  NSRC  level interrupt_request from each peripheral.
- `irq_exec`  out  NSRC  one-hot interrupt_executed pulse to the serviced peripheral.
- `global_ie`  in  1  status-register I flag from the core.
- `cpu_irq`  out  1  interrupt request to the core.
- `cpu_vector`  out  VW  vector number; valid while `cpu_irq`=1.
- `cpu_ack`  in  1  core has taken the vector (single-cycle pulse).
- `cpu_reti`  in  1  core executed RETI (single-cycle pulse).
- `in_service`  out  1  high from ack until handler return.

## Operation
- Reset values: `cpu_irq`=0, `cpu_vector`=0, `irq_exec`=0, `in_service`=0, state IDLE, winner register 0, round-robin pointer `NSRC-1`.
- States: IDLE, REQ, SERVICE, HOLD.
- IDLE, when `global_ie`=1 and `irq_req`≠0:
  - arbitrate and register the winner index;
  - set `cpu_vector` = `VEC_BASE` + winner;
  - set `cpu_irq`=1;
  - go to REQ.
- REQ, `cpu_ack`=1 (highest precedence in this state):
  - pulse `irq_exec[winner]` for one cycle;
  - clear `cpu_irq`, set `in_service`;
  - go to SERVICE.
- REQ, no ack, and either `irq_req[winner]`=0 or `global_ie`=0: withdraw. Clear `cpu_irq` and return to IDLE. No `irq_exec`.
- REQ, otherwise:
  - hold winner and vector stable; no re-arbitration;
  - a higher-priority request arriving now does not preempt.
- SERVICE:
  - all requests are ignored; there is no nesting;
  - on `cpu_reti`: clear `in_service`, go to HOLD.
- HOLD: lasts exactly one cycle with no arbitration, so the core executes one instruction after return. Then IDLE.
- Ignored inputs:
  - `cpu_ack` outside REQ;
  - `cpu_reti` outside SERVICE.
- Arbitration is fixed priority: the lowest set index wins (see Configuration).
- Vector arithmetic is unsigned and `VW` bits wide; the winner index is `$clog2(NSRC)` bits.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Request latency:
  - `irq_req` rises in cycle t with `global_ie`=1 and state IDLE;
  - `cpu_irq` and `cpu_vector` are valid in t+1.
- Acknowledge: `cpu_ack` in t gives `irq_exec` high in t+1 only, `cpu_irq` low in t+1, and `in_service` high in t+1.
- Return and next request:
  - `cpu_reti` in t: state is HOLD in t+1 and IDLE in t+2;
  - the next `cpu_irq` is at t+3 at the earliest.
- A peripheral's `irq_req` drops no earlier than one cycle after `irq_exec`. SERVICE masks that cycle.
- Reset asserted mid-operation, in any state:
  - all outputs clear immediately and asynchronously;
  - a pending ack or service is lost;
  - no `irq_exec` is generated.

## Configuration
- `IRQCTL_ROUND_ROBIN_EN` undefined: fixed priority, lowest index wins. The pointer register is not built.
- `IRQCTL_ROUND_ROBIN_EN` defined: rotating priority.
  - The search starts at pointer+1 and wraps modulo `NSRC`.
  - The pointer updates to the winner only on `cpu_ack`.
  - Withdrawn requests do not move the pointer.
  - Reset pointer `NSRC-1` makes index 0 highest priority first.

## Test plan
- Reset and single request. Hold `rst`=0, then release; set `irq_req`=0x04, `global_ie`=1.
  - Required: `cpu_irq`=1 and `cpu_vector`=3 one cycle later.
  - Ack: `irq_exec`=0x04 for one cycle, `in_service`=1.
- Fixed priority. `irq_req`=0x90 rises in one cycle.
  - Required: `cpu_vector`=5.
  - After ack and reti with bit 4 cleared, the next `cpu_vector`=8, three cycles after reti.
- Withdraw. In REQ for source 2, drop `irq_req[2]` before ack.
  - Required: `cpu_irq`=0 next cycle, `irq_exec` never pulses, state IDLE.
  - Repeat the sequence, dropping `global_ie` instead of the request; required response is the same.
- Masking. In SERVICE, assert `irq_req`=0x01 and pulse `cpu_ack`.
  - Required: no `cpu_irq` and no `irq_exec` until 3 cycles after `cpu_reti`.
- Reset mid-REQ. Assert `rst`=0 while `cpu_irq`=1.
  - Required: `cpu_irq`, `cpu_vector`, `in_service` all 0 without a clock edge.
  - After release with `irq_req` still set, re-request one cycle after the first active edge.
- Round robin, `IRQCTL_ROUND_ROBIN_EN` defined. Hold `irq_req`=0x03 through three ack/reti rounds.
  - Required: vectors 1, 2, 1.
  - Without the macro: vectors 1, 1, 1.

Source files
------------

// File: rtl/irq_ctl.sv
// Interrupt controller: arbitrates level requests into one vectored request for the core
// and runs the ack/reti handshake. Define IRQCTL_ROUND_ROBIN_EN for rotating priority.
module irq_ctl #(
    parameter int unsigned NSRC     = 8,
    parameter int unsigned VEC_BASE = 1,
    parameter int unsigned VW       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_req,
    output logic [NSRC-1:0] irq_exec,
    input  logic            global_ie,
    output logic            cpu_irq,
    output logic [VW-1:0]   cpu_vector,
    input  logic            cpu_ack,
    input  logic            cpu_reti,
    output logic            in_service
);

    localparam int unsigned IW = $clog2(NSRC);
    localparam logic [VW-1:0] VecBase = VW'(VEC_BASE);

    typedef enum logic [1:0] {StIdle, StReq, StService, StHold} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   winner_q, winner_d;
    logic [VW-1:0]   vector_d;
    logic            irq_d;
    logic [NSRC-1:0] exec_d;
    logic            in_service_d;
    logic [IW-1:0]   arb_idx;
    logic            arb_found;

`ifdef IRQCTL_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_q, ptr_d;

    // Search starts one past the last acknowledged source and wraps.
    always_comb begin
        int unsigned cand;
        arb_idx   = '0;
        arb_found = 1'b0;
        for (int unsigned k = 1; k <= NSRC; k++) begin
            cand = (32'(ptr_q) + k) % NSRC;
            if (!arb_found && irq_req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = IW'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= IW'(NSRC - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (!arb_found && irq_req[i]) begin
                arb_found = 1'b1;
                arb_idx   = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        vector_d     = cpu_vector;
        irq_d        = cpu_irq;
        exec_d       = '0;
        in_service_d = in_service;
`ifdef IRQCTL_ROUND_ROBIN_EN
        ptr_d        = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (global_ie && arb_found) begin
                    winner_d = arb_idx;
                    vector_d = VecBase + VW'(arb_idx);
                    irq_d    = 1'b1;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (cpu_ack) begin
                    exec_d[winner_q] = 1'b1;
                    irq_d            = 1'b0;
                    in_service_d     = 1'b1;
                    state_d          = StService;
`ifdef IRQCTL_ROUND_ROBIN_EN
                    ptr_d            = winner_q;
`endif
                end else if (!irq_req[winner_q] || !global_ie) begin
                    // Source or core gave up before ack: withdraw without a pulse.
                    irq_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            StService: begin
                if (cpu_reti) begin
                    in_service_d = 1'b0;
                    state_d      = StHold;
                end
            end
            StHold: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            winner_q   <= '0;
            cpu_vector <= '0;
            cpu_irq    <= 1'b0;
            irq_exec   <= '0;
            in_service <= 1'b0;
        end else begin
            state_q    <= state_d;
            winner_q   <= winner_d;
            cpu_vector <= vector_d;
            cpu_irq    <= irq_d;
            irq_exec   <= exec_d;
            in_service <= in_service_d;
        end
    end

endmodule

// File: tb/tb_irq_ctl.sv
// Scoreboard bench for irq_ctl: expected vectors and exec pulses are queued at stimulus
// time and checked by a monitor when cpu_irq rises or irq_exec pulses.
module tb_irq_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_req;
    logic [7:0] irq_exec;
    logic       global_ie;
    logic       cpu_irq;
    logic [4:0] cpu_vector;
    logic       cpu_ack;
    logic       cpu_reti;
    logic       in_service;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned exp_vec_q[$];
    int unsigned exp_exec_q[$];
    logic        prev_irq = 1'b0;

    irq_ctl #(.NSRC(8), .VEC_BASE(1), .VW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_req    (irq_req),
        .irq_exec   (irq_exec),
        .global_ie  (global_ie),
        .cpu_irq    (cpu_irq),
        .cpu_vector (cpu_vector),
        .cpu_ack    (cpu_ack),
        .cpu_reti   (cpu_reti),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor: pop expected values when the DUT produces a request or a pulse.
    always @(negedge clk) begin
        if (rst) begin
            if (cpu_irq && !prev_irq) begin
                if (exp_vec_q.size() == 0) check_eq("irq_unexpected", 32'(cpu_irq), 0);
                else check_eq("vector", 32'(cpu_vector), exp_vec_q.pop_front());
            end
            if (irq_exec != 8'h00) begin
                if (exp_exec_q.size() == 0) check_eq("exec_unexpected", 32'(irq_exec), 0);
                else check_eq("exec", 32'(irq_exec), exp_exec_q.pop_front());
            end
        end
        prev_irq = cpu_irq;
    end

    task automatic wait_irq();
        int n = 0;
        while (!cpu_irq && n < 10) begin
            tick();
            n++;
        end
        check_eq("irq_wait", 32'(cpu_irq), 1);
    endtask

    task automatic do_ack(input logic [7:0] exp_exec);
        exp_exec_q.push_back(32'(exp_exec));
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        check_eq("ack_insvc", 32'(in_service), 1);
        check_eq("ack_irq_low", 32'(cpu_irq), 0);
        tick();
        check_eq("exec_one_cycle", 32'(irq_exec), 0);
    endtask

    task automatic do_reti();
        cpu_reti = 1'b1;
        tick();
        cpu_reti = 1'b0;
        check_eq("reti_insvc", 32'(in_service), 0);
    endtask

    initial begin
        int unsigned rr_vec[3];
`ifdef IRQCTL_ROUND_ROBIN_EN
        rr_vec = '{1, 2, 1};
`else
        rr_vec = '{1, 1, 1};
`endif
        rst = 1'b0; irq_req = '0; global_ie = 1'b0; cpu_ack = 1'b0; cpu_reti = 1'b0;
        repeat (3) tick();
        check_eq("rst_irq", 32'(cpu_irq), 0);
        check_eq("rst_vec", 32'(cpu_vector), 0);
        check_eq("rst_exec", 32'(irq_exec), 0);
        check_eq("rst_insvc", 32'(in_service), 0);
        rst = 1'b1;
        tick();

        // Single request, one-cycle latency.
        irq_req = 8'h04; global_ie = 1'b1; exp_vec_q.push_back(3);
        tick();
        check_eq("s1_latency", 32'(cpu_irq), 1);
        do_ack(8'h04);
        irq_req = '0;
        do_reti();
        tick();

        // Fixed priority and return timing.
        irq_req = 8'h90; exp_vec_q.push_back(5);
        tick();
        check_eq("s2_latency", 32'(cpu_irq), 1);
        do_ack(8'h10);
        irq_req = 8'h80; exp_vec_q.push_back(8);
        do_reti();
        check_eq("s2_t1_hold", 32'(cpu_irq), 0);
        tick();
        check_eq("s2_t2_idle", 32'(cpu_irq), 0);
        tick();
        check_eq("s2_t3_req", 32'(cpu_irq), 1);
        do_ack(8'h80);
        irq_req = '0;
        do_reti();
        tick();

        // Withdraw by dropping the request, then by dropping global_ie.
        irq_req = 8'h04; exp_vec_q.push_back(3);
        tick();
        check_eq("wd1_req", 32'(cpu_irq), 1);
        irq_req = '0;
        tick();
        check_eq("wd1_drop", 32'(cpu_irq), 0);
        check_eq("wd1_insvc", 32'(in_service), 0);
        tick();
        irq_req = 8'h04; exp_vec_q.push_back(3);
        tick();
        check_eq("wd2_req", 32'(cpu_irq), 1);
        global_ie = 1'b0;
        tick();
        check_eq("wd2_drop", 32'(cpu_irq), 0);
        tick();
        check_eq("wd2_masked", 32'(cpu_irq), 0);
        global_ie = 1'b1; exp_vec_q.push_back(3);
        tick();
        check_eq("wd2_rereq", 32'(cpu_irq), 1);
        do_ack(8'h04);
        irq_req = '0;
        do_reti();
        tick();

        // Masking during service: stray ack and new request are ignored.
        irq_req = 8'h02; exp_vec_q.push_back(2);
        tick();
        do_ack(8'h02);
        irq_req = 8'h01;
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("mask_irq", 32'(cpu_irq), 0);
            check_eq("mask_exec", 32'(irq_exec), 0);
            tick();
        end
        exp_vec_q.push_back(1);
        do_reti();
        check_eq("mask_t1", 32'(cpu_irq), 0);
        tick();
        check_eq("mask_t2", 32'(cpu_irq), 0);
        tick();
        check_eq("mask_t3", 32'(cpu_irq), 1);
        do_ack(8'h01);
        irq_req = '0;
        do_reti();
        tick();

        // Asynchronous reset while requesting.
        irq_req = 8'h08; exp_vec_q.push_back(4);
        tick();
        check_eq("rr_pre_req", 32'(cpu_irq), 1);
        #2 rst = 1'b0;
        #1;
        check_eq("async_irq", 32'(cpu_irq), 0);
        check_eq("async_vec", 32'(cpu_vector), 0);
        check_eq("async_insvc", 32'(in_service), 0);
        tick();
        rst = 1'b1; exp_vec_q.push_back(4);
        tick();
        check_eq("post_rst_req", 32'(cpu_irq), 1);
        do_ack(8'h08);
        irq_req = '0;
        do_reti();
        tick();

        // Two sources held through three rounds.
        irq_req = 8'h03;
        for (int r = 0; r < 3; r++) begin
            exp_vec_q.push_back(rr_vec[r]);
            wait_irq();
            do_ack(8'(1 << (rr_vec[r] - 1)));
            if (r == 2) irq_req = '0;
            do_reti();
        end
        repeat (4) tick();
        check_eq("vec_q_empty", exp_vec_q.size(), 0);
        check_eq("exec_q_empty", exp_exec_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
